// File: rtl/tx_queue_8x9.sv
// tx_queue_8x9 : 8-entry x 9-bit transmit character queue for a SpaceWire link.
// The host writes N-Chars through a write-only Wishbone B4 pipelined slave.
// Characters drain toward the transmitter only while FCT-granted credit remains.
// Each FCT adds CREDIT_STEP. An FCT that would push credit past CREDIT_MAX is
// dropped and raises a sticky error.
module tx_queue_8x9 #(
    parameter int CREDIT_STEP = 8,
    parameter int CREDIT_MAX  = 56
) (
    input  logic       clk,
    input  logic       reset,
    // Wishbone write port
    input  logic       stb_i,
    input  logic [8:0] dat_i,
    output logic       ack_o,
    output logic       stall_o,
    // queue status
    output logic       full_o,
    output logic       empty_o,
    // link flow control and transmitter handshake
    input  logic       fct_i,
    input  logic       tx_rdy_i,
    output logic       nchar_o,
    output logic       lchar_o,
    output logic [7:0] char_o,
    output logic [5:0] credit_o,
    output logic       credit_err_o,
    // bench visibility
    output logic [7:0] occupied_tb,
    output logic [2:0] rp_tb,
    output logic [2:0] wp_tb
);

    localparam int DEPTH = 8;

    // Storage and control state
    logic [8:0] slot [DEPTH];
    logic [7:0] occupied;
    logic [2:0] rp;
    logic [2:0] wp;
    logic [5:0] credit;
    logic       credit_err;

    // Output registers
    logic       ack_p1;
    logic       nchar_p1;
    logic       lchar_p1;
    logic [7:0] char_p1;

    // Combinational decode
    logic       full;
    logic       empty;
    logic       accept;
    logic       ctrl_only;
    logic       store;
    logic       pop;
    logic [8:0] head;
    logic [6:0] credit_fct;
    logic       fct_overflow;
    logic [5:0] credit_nxt;
    logic       credit_err_nxt;
    logic [7:0] occupied_nxt;

    assign full  = &occupied;
    assign empty = ~|occupied;
    assign head  = slot[rp];

    // Write acceptance: FCT (00) and ESC (11) L-chars are acked but never queued
    always_comb begin
        accept    = stb_i & ~full;
        ctrl_only = dat_i[8] & ((dat_i[1:0] == 2'b00) | (dat_i[1:0] == 2'b11));
        store     = accept & ~ctrl_only;
    end

    // Pop needs a valid head slot, a ready transmitter and at least one credit
    always_comb begin
        pop = occupied[rp] & tx_rdy_i & (credit != 6'd0);
    end

    // Credit arithmetic: next = credit + STEP*fct - pop, overflowing FCT dropped
    always_comb begin
        credit_fct     = {1'b0, credit} + 7'(CREDIT_STEP) - {6'd0, pop};
        fct_overflow   = fct_i & (credit_fct > 7'(CREDIT_MAX));
        credit_nxt     = credit - {5'd0, pop};
        credit_err_nxt = credit_err;
        if (fct_i && !fct_overflow) begin
            credit_nxt = credit_fct[5:0];
        end
        if (fct_overflow) begin
            credit_err_nxt = 1'b1;
        end
    end

    // Occupancy: a simultaneous write and pop always target different slots
    always_comb begin
        occupied_nxt = occupied;
        if (pop) begin
            occupied_nxt[rp] = 1'b0;
        end
        if (store) begin
            occupied_nxt[wp] = 1'b1;
        end
    end

    // Control state: pointers, occupancy, credit and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupied   <= '0;
            rp         <= '0;
            wp         <= '0;
            credit     <= '0;
            credit_err <= 1'b0;
        end else begin
            occupied   <= occupied_nxt;
            credit     <= credit_nxt;
            credit_err <= credit_err_nxt;
            if (pop) begin
                rp <= rp + 3'd1;
            end
            if (store) begin
                wp <= wp + 3'd1;
            end
        end
    end

    // Character storage; stale contents are harmless because occupancy gates them
    always_ff @(posedge clk) begin
        if (store) begin
            slot[wp] <= dat_i;
        end
    end

    // Stage p1: registered ack and one-cycle transmit strobes with held payload
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_p1   <= 1'b0;
            nchar_p1 <= 1'b0;
            lchar_p1 <= 1'b0;
            char_p1  <= '0;
        end else begin
            ack_p1   <= accept;
            nchar_p1 <= pop & ~head[8];
            lchar_p1 <= pop & head[8];
            if (pop) begin
                char_p1 <= head[7:0];
            end
        end
    end

    assign ack_o        = ack_p1;
    assign stall_o      = full;
    assign full_o       = full;
    assign empty_o      = empty;
    assign nchar_o      = nchar_p1;
    assign lchar_o      = lchar_p1;
    assign char_o       = char_p1;
    assign credit_o     = credit;
    assign credit_err_o = credit_err;
    assign occupied_tb  = occupied;
    assign rp_tb        = rp;
    assign wp_tb        = wp;

endmodule
